// File: rtl/memory_map_pkg.sv
// Purpose: shared address map, sizes and loader state encoding for memory_system.
// Ports: none (package).
package memory_map_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned NUM_PORTS  = 4;
  localparam int unsigned PORT_BUS_W = NUM_PORTS * DATA_W;
  localparam int unsigned PROG_DEPTH = 128;
  localparam int unsigned RAM_DEPTH  = 96;
  localparam int unsigned MEM_IDX_W  = 7;
  localparam int unsigned PORT_IDX_W = 2;

  localparam logic [ADDR_W-1:0] PROG_BASE  = 8'h00;
  localparam logic [ADDR_W-1:0] PROG_LIMIT = 8'h7F;
  localparam logic [ADDR_W-1:0] RAM_BASE   = 8'h80;
  localparam logic [ADDR_W-1:0] RAM_LIMIT  = 8'hDF;
  localparam logic [ADDR_W-1:0] OUT_BASE   = 8'hE0;
  localparam logic [ADDR_W-1:0] OUT_LIMIT  = 8'hE3;
  localparam logic [ADDR_W-1:0] IN_BASE    = 8'hF0;
  localparam logic [ADDR_W-1:0] IN_LIMIT   = 8'hF3;

  // Last program address the loader may write; the counter saturates here.
  localparam logic [MEM_IDX_W-1:0] LOAD_CNT_MAX = 7'h7F;

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } load_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchronizer for signals asynchronous to clk.
// Ports: clk, reset (sync, active-high), i_d (async input), o_q (synchronized output).
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/memory_system.sv
// Purpose: CPU-side memory/I-O responder with program memory, data RAM,
//          output ports, synchronized input ports and a boot loader.
// Ports: clk, reset (sync, active-high)
//        address/to_memory/write -> from_memory : CPU bus, 1-cycle registered read
//        cpu_reset                              : holds the CPU in reset until loaded
//        load_valid/load_data/load_last -> load_ready : loader byte stream
//        port_in (async) / port_out (registered): four 8-bit ports each
module memory_system
  import memory_map_pkg::*;
#(
  parameter bit BOOT_LOAD = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     to_memory,
  input  logic                  write,
  output logic [DATA_W-1:0]     from_memory,
  output logic                  cpu_reset,
  input  logic                  load_valid,
  input  logic [DATA_W-1:0]     load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic [PORT_BUS_W-1:0] port_in,
  output logic [PORT_BUS_W-1:0] port_out
);

  load_state_t r_state;
  load_state_t w_next_state;

  logic [DATA_W-1:0]     r_prog [PROG_DEPTH];
  logic [DATA_W-1:0]     r_ram  [RAM_DEPTH];
  logic [MEM_IDX_W-1:0]  r_load_cnt;
  logic [DATA_W-1:0]     r_from_memory;
  logic [PORT_BUS_W-1:0] r_port_out;
  logic                  r_cpu_reset;
  logic                  r_load_ready;

  logic [PORT_BUS_W-1:0] w_port_sync;
  logic                  w_load_fire;
  logic                  w_is_prog;
  logic                  w_is_ram;
  logic                  w_is_out;
  logic                  w_is_in;
  logic [MEM_IDX_W-1:0]  w_prog_idx;
  logic [MEM_IDX_W-1:0]  w_ram_idx;
  logic [PORT_IDX_W-1:0] w_out_idx;
  logic [PORT_IDX_W-1:0] w_in_idx;
  logic [DATA_W-1:0]     w_rd_data;
  logic                  w_cpu_wr;
  logic                  w_wr_ram;
  logic                  w_wr_out;

  sync_2ff #(
    .WIDTH (PORT_BUS_W)
  ) u_port_in_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (port_in),
    .o_q   (w_port_sync)
  );

  // Address decode and read mux.
  always_comb begin
    w_is_prog  = (address <= PROG_LIMIT);
    w_is_ram   = (address >= RAM_BASE) && (address <= RAM_LIMIT);
    w_is_out   = (address >= OUT_BASE) && (address <= OUT_LIMIT);
    w_is_in    = (address >= IN_BASE)  && (address <= IN_LIMIT);
    w_prog_idx = MEM_IDX_W'(address - PROG_BASE);
    w_ram_idx  = MEM_IDX_W'(address - RAM_BASE);
    w_out_idx  = PORT_IDX_W'(address - OUT_BASE);
    w_in_idx   = PORT_IDX_W'(address - IN_BASE);
    w_rd_data  = '0;
    if (w_is_prog) begin
      w_rd_data = r_prog[w_prog_idx];
    end else if (w_is_ram) begin
      w_rd_data = r_ram[w_ram_idx];
    end else if (w_is_out) begin
      w_rd_data = r_port_out[{w_out_idx, 3'b000} +: DATA_W];
    end else if (w_is_in) begin
      w_rd_data = w_port_sync[{w_in_idx, 3'b000} +: DATA_W];
    end
  end

  // CPU writes only take effect while running and outside reset.
  assign w_cpu_wr = write && (r_state == S_RUN) && !reset;
  assign w_wr_ram = w_cpu_wr && w_is_ram;
  assign w_wr_out = w_cpu_wr && w_is_out;

  // Loader state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BOOT_LOAD ? S_LOAD : S_RELEASE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Loader next-state logic.
  always_comb begin
    w_next_state = r_state;
    w_load_fire  = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_load_fire = load_valid;
        if (load_valid && (load_last || (r_load_cnt == LOAD_CNT_MAX))) begin
          w_next_state = S_RELEASE;
        end
      end
      S_RELEASE: w_next_state = S_RUN;
      S_RUN:     w_next_state = S_RUN;
      default:   w_next_state = S_RUN;
    endcase
  end

  // Registered handshake/CPU-reset outputs track the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_reset  <= 1'b1;
      r_load_ready <= BOOT_LOAD;
    end else begin
      r_cpu_reset  <= (w_next_state != S_RUN);
      r_load_ready <= (w_next_state == S_LOAD);
    end
  end

  // Load counter saturates at the top program address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_cnt <= '0;
    end else if (w_load_fire && (r_load_cnt != LOAD_CNT_MAX)) begin
      r_load_cnt <= r_load_cnt + MEM_IDX_W'(1);
    end
  end

  // Arrays keep their contents across reset.
  always_ff @(posedge clk) begin
    if (w_load_fire && !reset) begin
      r_prog[r_load_cnt] <= load_data;
    end
    if (w_wr_ram) begin
      r_ram[w_ram_idx] <= to_memory;
    end
  end

  // Output port registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_port_out <= '0;
    end else if (w_wr_out) begin
      r_port_out[{w_out_idx, 3'b000} +: DATA_W] <= to_memory;
    end
  end

  // Read data register; write-first on writable addresses.
  always_ff @(posedge clk) begin
    if (reset || (r_state != S_RUN)) begin
      r_from_memory <= '0;
    end else if (write && (w_is_ram || w_is_out)) begin
      r_from_memory <= to_memory;
    end else begin
      r_from_memory <= w_rd_data;
    end
  end

  assign from_memory = r_from_memory;
  assign port_out    = r_port_out;
  assign cpu_reset   = r_cpu_reset;
  assign load_ready  = r_load_ready;

endmodule

// File: tb/tb_memory_system.sv
// Purpose: directed self-checking bench for memory_system (boot-load and no-boot-load builds).
module tb_memory_system;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  address;
  logic [7:0]  to_memory;
  logic        write;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic [31:0] port_in;

  logic [7:0]  from_memory;
  logic        cpu_reset;
  logic        load_ready;
  logic [31:0] port_out;

  logic        nb_reset;
  logic [7:0]  nb_from_memory;
  logic        nb_cpu_reset;
  logic        nb_load_ready;
  logic [31:0] nb_port_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] prog_bytes [6];

  memory_system #(.BOOT_LOAD(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .to_memory   (to_memory),
    .write       (write),
    .from_memory (from_memory),
    .cpu_reset   (cpu_reset),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .port_in     (port_in),
    .port_out    (port_out)
  );

  memory_system #(.BOOT_LOAD(1'b0)) dut_nb (
    .clk         (clk),
    .reset       (nb_reset),
    .address     (address),
    .to_memory   (to_memory),
    .write       (write),
    .from_memory (nb_from_memory),
    .cpu_reset   (nb_cpu_reset),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (nb_load_ready),
    .port_in     (port_in),
    .port_out    (nb_port_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
    address = a;
    write   = 1'b0;
    tick();
    chk(tag, 32'(from_memory), 32'(exp));
  endtask

  initial begin
    prog_bytes[0] = 8'h86; prog_bytes[1] = 8'h2A; prog_bytes[2] = 8'h96;
    prog_bytes[3] = 8'hE0; prog_bytes[4] = 8'h20; prog_bytes[5] = 8'h00;

    reset = 1'b1; nb_reset = 1'b1;
    address = '0; to_memory = '0; write = 1'b0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0; port_in = '0;

    // Reset state of both builds.
    tick();
    tick();
    chk("rst_from_memory", 32'(from_memory), 32'h0);
    chk("rst_port_out",    port_out,         32'h0);
    chk("rst_cpu_reset",   32'(cpu_reset),   32'h1);
    chk("rst_load_ready",  32'(load_ready),  32'h1);
    chk("nb_rst_cpu_reset",  32'(nb_cpu_reset),  32'h1);
    chk("nb_rst_load_ready", 32'(nb_load_ready), 32'h0);

    // No-boot build: released after one RELEASE cycle, never ready.
    nb_reset = 1'b0;
    tick();
    chk("nb_cpu_reset_low",  32'(nb_cpu_reset),  32'h0);
    chk("nb_load_ready_run", 32'(nb_load_ready), 32'h0);
    tick();
    chk("nb_load_ready_run2", 32'(nb_load_ready), 32'h0);

    // Boot load of six bytes.
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      load_valid = 1'b1;
      load_data  = prog_bytes[i];
      load_last  = (i == 5);
      tick();
      if (i == 4) chk("ready_before_last", 32'(load_ready), 32'h1);
    end
    chk("ready_after_last",   32'(load_ready),  32'h0);
    chk("cpurst_after_last",  32'(cpu_reset),   32'h1);
    chk("fm_zero_release",    32'(from_memory), 32'h0);
    load_valid = 1'b0; load_last = 1'b0;
    tick();
    chk("cpurst_run", 32'(cpu_reset), 32'h0);

    for (int i = 0; i < 6; i++) cpu_read(8'(i), prog_bytes[i], $sformatf("prog_rd_%0d", i));

    // RAM write-first, then read back.
    address = 8'h80; to_memory = 8'h5A; write = 1'b1;
    tick();
    chk("ram_wr_first", 32'(from_memory), 32'h5A);
    cpu_read(8'h80, 8'h5A, "ram_rd_80");
    address = 8'hDF; to_memory = 8'h3C; write = 1'b1;
    tick();
    cpu_read(8'hDF, 8'h3C, "ram_rd_df");

    // Program memory ignores CPU writes; read-during-write returns stored byte.
    address = 8'h02; to_memory = 8'h11; write = 1'b1;
    tick();
    chk("prog_wr_ignored_rdw", 32'(from_memory), 32'h96);
    cpu_read(8'h02, 8'h96, "prog_rd_after_wr");

    // Output port 2.
    address = 8'hE2; to_memory = 8'hC3; write = 1'b1;
    tick();
    chk("port_out_wr",     port_out,         32'h00C3_0000);
    chk("port_out_wr_rdw", 32'(from_memory), 32'hC3);
    cpu_read(8'hE2, 8'hC3, "port_out_rd");

    // Input port write ignored.
    address = 8'hF1; to_memory = 8'hFF; write = 1'b1;
    tick();
    chk("in_wr_port_out", port_out,         32'h00C3_0000);
    chk("in_wr_rdw",      32'(from_memory), 32'h00);
    write = 1'b0;
    cpu_read(8'hE8, 8'h00, "unmapped_rd");

    // Input port synchronizer latency.
    address = 8'hF1;
    port_in = 32'h0000_7E00;
    tick();
    chk("port_in_edge1", 32'(from_memory), 32'h00);
    tick();
    chk("port_in_edge2", 32'(from_memory), 32'h00);
    tick();
    chk("port_in_edge3", 32'(from_memory), 32'h7E);

    // Reset while running.
    reset = 1'b1;
    tick();
    chk("rr_port_out",   port_out,         32'h0);
    chk("rr_cpu_reset",  32'(cpu_reset),   32'h1);
    chk("rr_load_ready", 32'(load_ready),  32'h1);
    chk("rr_from_mem",   32'(from_memory), 32'h0);
    reset = 1'b0;
    load_valid = 1'b1; load_data = 8'h77; load_last = 1'b1;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    tick();
    chk("rr_cpu_run", 32'(cpu_reset), 32'h0);
    cpu_read(8'h00, 8'h77, "reload_rd_00");
    cpu_read(8'h01, 8'h2A, "reload_rd_01");
    cpu_read(8'h04, 8'h20, "reload_rd_04");
    cpu_read(8'h80, 8'h5A, "ram_kept");

    // Full 128-byte stream without load_last.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 128; i++) begin
      load_valid = 1'b1;
      load_data  = 8'(i) ^ 8'hA5;
      load_last  = 1'b0;
      tick();
      if (i == 126) chk("full_ready_126", 32'(load_ready), 32'h1);
    end
    chk("full_ready_127", 32'(load_ready), 32'h0);
    load_data = 8'hEE;
    tick();
    chk("full_cpu_run", 32'(cpu_reset), 32'h0);
    load_valid = 1'b0;
    cpu_read(8'h00, 8'hA5, "full_rd_00");
    cpu_read(8'h7F, 8'hDA, "full_rd_7f");
    cpu_read(8'h40, 8'hE5, "full_rd_40");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
